mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port, word-indexed 16 KB data memory `mem` (4096 × 32, one-cycle registered read, synchronous write). It shares the memory between the instruction-fetch port and the load/store port with round-robin fairness. It converts byte addresses to word indices and performs read-modify-write for partial (byte/halfword) stores, which the memory cannot do natively.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the single-port data memory between the
// instruction-fetch port and the load/store port. It also does read-modify-write
// for partial stores.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned IdxW  = 12;
  localparam int unsigned LaneW = 8;
  localparam int unsigned Lanes = 4;

  typedef enum logic {S_IDLE, S_MERGE} state_e;
  typedef enum logic {G_IF, G_D} grant_e;

  state_e                 state_q, state_d;
  grant_e                 last_q, last_d;
  logic                   if_pend_q, if_pend_d;
  logic                   d_pend_q, d_pend_d;
  logic [IdxW-1:0]        m_idx_q, m_idx_d;
  logic [31:0]            m_wdata_q, m_wdata_d;
  logic [Lanes-1:0]       m_be_q, m_be_d;
  logic                   grant_if, grant_d;
  logic [31:0]            merge_data;
  logic [IdxW-1:0]        if_idx, d_idx;
  logic                   unused_addr_bits;

  // Word indices; the upper and byte-offset address bits are deliberately dropped.
  assign if_idx = if_addr[13:2];
  assign d_idx  = d_addr[13:2];
  assign unused_addr_bits = ^{if_addr[31:14], if_addr[1:0], d_addr[31:14], d_addr[1:0]};

  // Read data is shared; each rvalid qualifies it for its own port.
  assign if_rdata  = mem_read_data;
  assign d_rdata   = mem_read_data;
  assign if_rvalid = if_pend_q & ~rst;
  assign d_rvalid  = d_pend_q & ~rst;

  // Byte-lane merge of captured store data over the word read in the accept cycle.
  always_comb begin
    merge_data = mem_read_data;
    for (int k = 0; k < Lanes; k++) begin
      if (m_be_q[k]) merge_data[k*LaneW +: LaneW] = m_wdata_q[k*LaneW +: LaneW];
    end
  end

  // Arbitration, memory command generation and next-state logic.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    if_pend_d      = 1'b0;
    d_pend_d       = 1'b0;
    m_idx_d        = m_idx_q;
    m_wdata_d      = m_wdata_q;
    m_be_d         = m_be_q;
    grant_if       = 1'b0;
    grant_d        = 1'b0;
    if_ready       = 1'b0;
    d_ready        = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (if_req && d_req) begin
            grant_d  = (last_q == G_IF);
            grant_if = (last_q == G_D);
          end else begin
            grant_if = if_req;
            grant_d  = d_req;
          end
          if (grant_if) begin
            if_ready  = 1'b1;
            last_d    = G_IF;
            mem_addr  = AddrW'(if_idx);
            if_pend_d = 1'b1;
          end else if (grant_d) begin
            d_ready = 1'b1;
            last_d  = G_D;
            if (!d_we) begin
              mem_addr = AddrW'(d_idx);
              d_pend_d = 1'b1;
            end else if (d_be == 4'hF) begin
              mem_addr       = AddrW'(d_idx);
              mem_write_en   = 1'b1;
              mem_write_data = d_wdata;
            end else if (d_be != 4'h0) begin
              mem_addr  = AddrW'(d_idx);
              m_idx_d   = d_idx;
              m_wdata_d = d_wdata;
              m_be_d    = d_be;
              state_d   = S_MERGE;
            end
          end
        end
        S_MERGE: begin
          mem_write_en   = 1'b1;
          mem_addr       = AddrW'(m_idx_q);
          mem_write_data = merge_data;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, grant history, pending-rvalid and merge-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= G_IF;
      if_pend_q <= 1'b0;
      d_pend_q  <= 1'b0;
      m_idx_q   <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      if_pend_q <= if_pend_d;
      d_pend_q  <= d_pend_d;
      m_idx_q   <= m_idx_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table with expected readys/write enable,
// a shadow memory and a read-response scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem_arr [4096];
  logic [31:0] shadow  [4096];
  logic        preload;

  int total;
  int bad;
  int cyc;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        e_ifr;
    logic        e_dr;
    logic        e_we;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[$];
  logic        mpend;
  logic [11:0] m_idx;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_be           (d_be),
    .d_ready        (d_ready),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, synchronous write, preload on demand.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (mem_write_en) begin
      mem_arr[mem_addr[11:0]] <= mem_write_data;
    end
    mem_read_data <= mem_arr[mem_addr[11:0]];
  end

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic [3:0] be,
                              logic eif, logic ed, logic ewe);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.d_be = be;
    v.e_ifr = eif; v.e_dr = ed; v.e_we = ewe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t        e;
    logic        e_ifv;
    logic        e_dv;
    logic [31:0] edata;
    logic [31:0] merged;
    logic [11:0] idx;
    @(posedge clk);
    #1;
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; d_req = v.d_req;
    d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_be = v.d_be;
    @(negedge clk);
    cyc++;
    check("if_ready", 32'(if_ready), 32'(v.e_ifr));
    check("d_ready", 32'(d_ready), 32'(v.e_dr));
    check("mem_write_en", 32'(mem_write_en), 32'(v.e_we));
    if (v.rst) begin
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_write_data, 32'h0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
      sbq.delete();
      mpend = 1'b0;
    end else begin
      e_ifv = 1'b0; e_dv = 1'b0; edata = 32'h0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        e_ifv = ~e.is_d; e_dv = e.is_d; edata = e.data;
      end
      check("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
      check("d_rvalid", 32'(d_rvalid), 32'(e_dv));
      if (e_ifv) check("if_rdata", if_rdata, edata);
      if (e_dv) check("d_rdata", d_rdata, edata);
      if (mpend) begin
        merged = shadow[m_idx];
        for (int k = 0; k < 4; k++) if (m_be[k]) merged[k*8 +: 8] = m_wdata[k*8 +: 8];
        check("merge_addr", mem_addr, 32'(m_idx));
        check("merge_wdata", mem_write_data, merged);
        shadow[m_idx] = merged;
        mpend = 1'b0;
      end else if (v.e_ifr) begin
        idx = v.if_addr[13:2];
        check("fetch_addr", mem_addr, 32'(idx));
        sbq.push_back('{is_d: 1'b0, data: shadow[idx], due: cyc + 1});
      end else if (v.e_dr) begin
        idx = v.d_addr[13:2];
        if (!v.d_we) begin
          check("load_addr", mem_addr, 32'(idx));
          sbq.push_back('{is_d: 1'b1, data: shadow[idx], due: cyc + 1});
        end else if (v.d_be == 4'hF) begin
          check("store_addr", mem_addr, 32'(idx));
          check("store_wdata", mem_write_data, v.d_wdata);
          shadow[idx] = v.d_wdata;
        end else if (v.d_be != 4'h0) begin
          check("rmw_read_addr", mem_addr, 32'(idx));
          mpend = 1'b1; m_idx = idx; m_wdata = v.d_wdata; m_be = v.d_be;
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mpend = 1'b0;
    m_idx = '0; m_wdata = '0; m_be = '0;
    preload = 1'b1;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    for (int i = 0; i < 4096; i++) shadow[i] = 32'hC0DE_0000 | 32'(i);
    @(posedge clk);
    #1 preload = 1'b0;

    // rst  ifq ifaddr          dq we daddr           wdata           be     eif ed we
    tbl.push_back(mk(1, 1, 32'h0000_0010, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h0000_0010, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0010, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0010, 0, 0, 32'h0,         32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0010, 0, 0, 32'h0,         32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'hFFFF_C010, 0, 0, 32'h0,         32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         32'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0100, 1, 0, 32'h0000_0200, 32'h0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0104, 1, 0, 32'h0000_0204, 32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0000_0108, 1, 0, 32'h0000_0208, 32'h0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h0000_010C, 1, 0, 32'h0000_020C, 32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         32'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0000_4020, 32'h0,         4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0000_0030, 32'h0,         4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,         32'h0,         4'h0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // Partial store to word 8, contended request during MERGE, read-back.
    apply(mk(0, 0, 32'h0,         1, 1, 32'h0000_0020, 32'h0000_5500, 4'b0010, 0, 1, 0));
    apply(mk(0, 1, 32'h0000_0010, 1, 0, 32'h0000_0020, 32'h0,         4'h0,    0, 0, 1));
    apply(mk(0, 1, 32'h0000_0010, 1, 0, 32'h0000_0020, 32'h0,         4'h0,    1, 0, 0));
    apply(mk(0, 0, 32'h0,         1, 0, 32'h0000_0020, 32'h0,         4'h0,    0, 1, 0));
    apply(mk(0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         4'h0,    0, 0, 0));
    check("merged_word8", shadow[8], 32'hDEAD_55EF);

    // Reset landing on the MERGE cycle must abort the write.
    apply(mk(0, 0, 32'h0, 1, 1, 32'h0000_0020, 32'h0000_00AA, 4'b0001, 0, 1, 0));
    apply(mk(1, 0, 32'h0, 0, 0, 32'h0,         32'h0,         4'h0,    0, 0, 0));
    apply(mk(0, 0, 32'h0, 1, 0, 32'h0000_0020, 32'h0,         4'h0,    0, 1, 0));
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0,         32'h0,         4'h0,    0, 0, 0));

    // Partial store followed by a held load to the same word at N+2.
    apply(mk(0, 0, 32'h0, 1, 1, 32'h0000_0040, 32'h1234_0000, 4'b1100, 0, 1, 0));
    apply(mk(0, 0, 32'h0, 1, 0, 32'h0000_0040, 32'h0,         4'h0,    0, 0, 1));
    apply(mk(0, 0, 32'h0, 1, 0, 32'h0000_0040, 32'h0,         4'h0,    0, 1, 0));
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0,         32'h0,         4'h0,    0, 0, 0));
    check("merged_word16", shadow[16], 32'h1234_0010);

    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
